fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 115 +++++++++++
 tb/tb_fifo_uart_tx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a show-ahead FIFO: start bit, LSB-first data,
// one or two stop bits, with back-to-back frames when data keeps coming.
`timescale 1ns/1ps
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_valid,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_pop,
  output logic                  tx,
  output logic                  busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_WIDTH - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [BW-1:0] r_bit, w_bit_n;
  logic r_stop, w_stop_n;
  logic [DATA_WIDTH-1:0] r_sh, w_sh_n;
  logic r_tx, w_tx_n;
  logic w_bit_end;
  logic w_stop_last;

  assign w_bit_end   = (r_cnt == CNT_MAX);
  assign w_stop_last = (r_state == S_STOP) && w_bit_end &&
                       (r_stop == STOP_LAST);
  assign fifo_pop = fifo_valid && !rst &&
                    ((r_state == S_IDLE) || w_stop_last);
  assign tx   = r_tx;
  assign busy = (r_state != S_IDLE);

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = w_bit_end ? '0 : r_cnt + 1'b1;
    w_bit_n   = r_bit;
    w_stop_n  = r_stop;
    w_sh_n    = r_sh;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_n = '0;
        if (fifo_pop) begin
          w_state_n = S_START;
          w_sh_n    = fifo_data;
        end
      end
      S_START: begin
        if (w_bit_end) w_state_n = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_sh_n = r_sh >> 1;
          if (r_bit == BIT_MAX) begin
            w_state_n = S_STOP;
            w_bit_n   = '0;
          end else begin
            w_bit_n = r_bit + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_stop == STOP_LAST) begin
            w_stop_n = 1'b0;
            if (fifo_pop) begin
              w_state_n = S_START;
              w_sh_n    = fifo_data;
            end else begin
              w_state_n = S_IDLE;
            end
          end else begin
            w_stop_n = r_stop + 1'b1;
          end
        end
      end
    endcase
    // Line level is precomputed for the next state so tx comes from a flop.
    w_tx_n = (w_state_n == S_DATA) ? w_sh_n[0] :
             (w_state_n != S_START);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_stop  <= 1'b0;
      r_sh    <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_stop  <= w_stop_n;
      r_sh    <= w_sh_n;
      r_tx    <= w_tx_n;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one- and two-stop-bit instances,
// CLKS_PER_BIT=4, DATA_WIDTH=8.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_valid, a_pop, a_tx, a_busy;
  logic [7:0] a_data;
  logic       b_valid, b_pop, b_tx, b_busy;
  logic [7:0] b_data;

  int checks = 0;
  int errors = 0;
  int pops;

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .fifo_valid(a_valid), .fifo_data(a_data),
    .fifo_pop(a_pop), .tx(a_tx), .busy(a_busy)
  );

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) u_b (
    .clk(clk), .rst(rst), .fifo_valid(b_valid), .fifo_data(b_data),
    .fifo_pop(b_pop), .tx(b_tx), .busy(b_busy)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #3;
  endtask

  // Expected line level at cycle i of a frame (i=0 is the first start cycle).
  function automatic logic exp_tx(input logic [7:0] d, input int i);
    logic [7:0] s;
    if (i < 4) return 1'b0;
    if (i < 36) begin
      s = d >> ((i - 4) / 4);
      return s[0];
    end
    return 1'b1;
  endfunction

  initial begin
    rst = 1'b1;
    a_valid = 1'b1;
    a_data = 8'h5A;
    b_valid = 1'b0;
    b_data = 8'h00;
    cyc();
    cyc();
    check("rst_tx", a_tx, 1'b1);
    check("rst_busy", a_busy, 1'b0);
    check("rst_pop_valid_hi", a_pop, 1'b0);
    check("rst_b_tx", b_tx, 1'b1);

    // Empty FIFO
    a_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      check("empty_tx", a_tx, 1'b1);
      check("empty_busy", a_busy, 1'b0);
      check("empty_pop", a_pop, 1'b0);
    end

    // Single frame 0xA5
    a_data = 8'hA5;
    a_valid = 1'b1;
    #1;
    check("single_pop", a_pop, 1'b1);
    check("single_pop_tx", a_tx, 1'b1);
    cyc();
    a_valid = 1'b0;
    #1;
    for (int i = 0; i < 40; i++) begin
      check("single_tx", a_tx, exp_tx(8'hA5, i));
      check("single_busy", a_busy, 1'b1);
      check("single_nopop", a_pop, 1'b0);
      cyc();
    end
    check("single_end_busy", a_busy, 1'b0);
    check("single_end_tx", a_tx, 1'b1);

    // Back-to-back 0x00 then 0xFF
    a_data = 8'h00;
    a_valid = 1'b1;
    #1;
    check("b2b_pop0", a_pop, 1'b1);
    pops = 1;
    cyc();
    a_data = 8'hFF;
    #1;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 40; i++) begin
        if (f == 1 && i == 0) begin
          a_valid = 1'b0;
          #1;
        end
        if (a_pop) pops++;
        check("b2b_tx", a_tx, exp_tx(f == 0 ? 8'h00 : 8'hFF, i));
        check("b2b_busy", a_busy, 1'b1);
        check("b2b_pop", a_pop, (f == 0 && i == 39));
        cyc();
      end
    end
    checks++;
    assert (pops === 2) else begin
      errors++;
      $error("FAIL b2b_pops observed=%0d expected=2", pops);
    end
    check("b2b_end_busy", a_busy, 1'b0);

    // Reset during DATA bit 3 with the FIFO still non-empty
    a_data = 8'h0F;
    a_valid = 1'b1;
    #1;
    check("rmid_pop", a_pop, 1'b1);
    cyc();
    for (int i = 0; i < 18; i++) begin
      check("rmid_tx", a_tx, exp_tx(8'h0F, i));
      check("rmid_nopop", a_pop, 1'b0);
      cyc();
    end
    rst = 1'b1;
    #1;
    check("rmid_rst_pop", a_pop, 1'b0);
    cyc();
    check("rmid_after_tx", a_tx, 1'b1);
    check("rmid_after_busy", a_busy, 1'b0);
    check("rmid_rst_idle_pop", a_pop, 1'b0);
    rst = 1'b0;
    #1;
    check("rmid_first_pop", a_pop, 1'b1);
    cyc();
    a_valid = 1'b0;
    #1;
    check("rmid_restart_busy", a_busy, 1'b1);
    for (int i = 0; i < 40; i++) begin
      check("rmid_re_tx", a_tx, exp_tx(8'h0F, i));
      cyc();
    end
    check("rmid_re_end_busy", a_busy, 1'b0);

    // Input changes mid-frame are ignored
    a_data = 8'h55;
    a_valid = 1'b1;
    #1;
    check("chg_pop", a_pop, 1'b1);
    cyc();
    a_valid = 1'b0;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) a_data = 8'hAA;
      if (i == 14) a_valid = 1'b1;
      if (i == 22) a_valid = 1'b0;
      #1;
      check("chg_tx", a_tx, exp_tx(8'h55, i));
      check("chg_nopop", a_pop, 1'b0);
      cyc();
    end
    check("chg_end_busy", a_busy, 1'b0);

    // Two stop bits, 0x3C: 44-cycle frame
    b_data = 8'h3C;
    b_valid = 1'b1;
    #1;
    check("sb2_pop", b_pop, 1'b1);
    cyc();
    b_valid = 1'b0;
    #1;
    for (int i = 0; i < 44; i++) begin
      check("sb2_tx", b_tx, exp_tx(8'h3C, i));
      check("sb2_busy", b_busy, 1'b1);
      check("sb2_nopop", b_pop, 1'b0);
      cyc();
    end
    check("sb2_end_busy", b_busy, 1'b0);
    check("sb2_end_tx", b_tx, 1'b1);
    check("sb2_a_idle", a_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
